// File: rtl/s713_bist_pkg.sv
// Shared constants, state encoding and MISR step for the s713 BIST harness.
// Also holds the response packing order used by the stimulus sequencer.
package s713_bist_pkg;

  localparam int W = 23;
  localparam logic [W-1:0] POLY = 23'h000021;
  localparam logic [W-1:0] SEED = 23'h000000;

  // RESP is packed {G107,G83,...,G101BF}, MSB first
  localparam int RESP_BIT_G107   = W - 1;
  localparam int RESP_BIT_G83    = W - 2;
  localparam int RESP_BIT_G101BF = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [W-1:0] misr_next(
    input logic [W-1:0] s,
    input logic [W-1:0] d
  );
    return ({s[W-2:0], 1'b0} ^ (s[W-1] ? POLY : '0)) ^ d;
  endfunction

endpackage

// File: rtl/s713_misr_reg.sv
// W-bit MISR register: seed load has priority over compaction.
// Asynchronous active-high reset returns the register to SEED.
module s713_misr_reg
  import s713_bist_pkg::*;
(
  input  logic         i_ck,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_seed,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_sig
);

  logic [W-1:0] r_sig;

  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      r_sig <= SEED;
    end else if (i_load) begin
      r_sig <= i_seed;
    end else if (i_en) begin
      r_sig <= misr_next(r_sig, i_data);
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/s713_resp_compactor.sv
// Response compactor: folds NVEC s713 output vectors into a MISR signature
// and flags PASS when the final signature matches GOLDEN.
module s713_resp_compactor
  import s713_bist_pkg::*;
#(
  parameter int            NVEC   = 256,
  parameter logic [W-1:0]  GOLDEN = 23'h000000,
  localparam int           CW     = $clog2(NVEC + 1)
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          START,
  input  logic          VALID,
  input  logic [W-1:0]  RESP,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASS,
  output logic [W-1:0]  SIG,
  output logic [CW-1:0] VCNT
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_vcnt;
  logic [CW-1:0] w_vcnt_nxt;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_pass_nxt;
  logic          w_load;
  logic          w_en;
  logic [W-1:0]  w_sig;
  logic [W-1:0]  w_sig_nxt;

  s713_misr_reg u_misr (
    .i_ck   (CK),
    .i_rst  (RST),
    .i_load (w_load),
    .i_en   (w_en),
    .i_seed (SEED),
    .i_data (RESP),
    .o_sig  (w_sig)
  );

  // PASS is judged on the signature the final vector produces
  assign w_sig_nxt = misr_next(w_sig, RESP);

  always_comb begin
    w_state_nxt = r_state;
    w_vcnt_nxt  = r_vcnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    w_load      = 1'b0;
    w_en        = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (START) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
          w_vcnt_nxt  = '0;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
        end
      end
      S_RUN: begin
        if (VALID) begin
          w_en       = 1'b1;
          w_vcnt_nxt = r_vcnt + 1'b1;
          if (r_vcnt == CW'(NVEC - 1)) begin
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_sig_nxt == GOLDEN);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_vcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vcnt  <= w_vcnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign PASS = r_pass;
  assign SIG  = w_sig;
  assign VCNT = r_vcnt;

endmodule

// File: tb/tb_s713_resp_compactor.sv
// Directed bench for s713_resp_compactor: a long-run and a 4-vector
// instance share stimulus; expected signatures are worked out by hand.
module tb_s713_resp_compactor;

  localparam logic [22:0] GOLD4 = 23'h400258;

  logic        CK;
  logic        RST;
  logic        START;
  logic        VALID;
  logic [22:0] RESP;

  logic        busy_b, done_b, pass_b;
  logic [22:0] sig_b;
  logic [8:0]  vcnt_b;
  logic        busy_s, done_s, pass_s;
  logic [22:0] sig_s;
  logic [2:0]  vcnt_s;

  int n_chk;
  int n_fail;

  s713_resp_compactor #(
    .NVEC   (256),
    .GOLDEN (23'h000000)
  ) u_big (
    .CK    (CK),
    .RST   (RST),
    .START (START),
    .VALID (VALID),
    .RESP  (RESP),
    .BUSY  (busy_b),
    .DONE  (done_b),
    .PASS  (pass_b),
    .SIG   (sig_b),
    .VCNT  (vcnt_b)
  );

  s713_resp_compactor #(
    .NVEC   (4),
    .GOLDEN (GOLD4)
  ) u_small (
    .CK    (CK),
    .RST   (RST),
    .START (START),
    .VALID (VALID),
    .RESP  (RESP),
    .BUSY  (busy_s),
    .DONE  (done_s),
    .PASS  (pass_s),
    .SIG   (sig_s),
    .VCNT  (vcnt_s)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic drive(
    input logic        st,
    input logic        v,
    input logic [22:0] d
  );
    START = st;
    VALID = v;
    RESP  = d;
    tick();
    START = 1'b0;
    VALID = 1'b0;
    RESP  = '0;
  endtask

  task automatic rst_pulse();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    RST    = 1'b1;
    START  = 1'b0;
    VALID  = 1'b0;
    RESP   = '0;
    #12;
    check("rst_sig",  32'(sig_b),  32'h0);
    check("rst_vcnt", 32'(vcnt_b), 32'h0);
    check("rst_busy", 32'(busy_b), 32'h0);
    check("rst_done", 32'(done_b), 32'h0);
    check("rst_pass", 32'(pass_b), 32'h0);
    RST = 1'b0;
    tick();

    drive(1'b0, 1'b1, 23'h000055);
    check("idle_valid_sig",  32'(sig_b),  32'h0);
    check("idle_valid_vcnt", 32'(vcnt_b), 32'h0);
    check("idle_busy",       32'(busy_b), 32'h0);

    drive(1'b1, 1'b0, '0);
    check("start_busy", 32'(busy_b), 32'h1);
    check("start_vcnt", 32'(vcnt_b), 32'h0);
    drive(1'b0, 1'b1, 23'h000001);
    check("shift1_sig",  32'(sig_b),  32'h1);
    check("shift1_vcnt", 32'(vcnt_b), 32'h1);
    drive(1'b0, 1'b1, 23'h000000);
    check("shift2_sig",  32'(sig_b),  32'h2);
    check("shift2_vcnt", 32'(vcnt_b), 32'h2);

    rst_pulse();
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 23'h400000);
    check("tap_load", 32'(sig_b), 32'h400000);
    drive(1'b0, 1'b1, 23'h000000);
    check("tap_fb", 32'(sig_b), 32'h000021);

    rst_pulse();
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b1, 23'h1234AB);
    check("mid_sig",  32'(sig_b),  32'h1234AB);
    check("mid_vcnt", 32'(vcnt_b), 32'h5);
    #3;
    RST = 1'b1;
    #1;
    check("async_sig",    32'(sig_b),  32'h0);
    check("async_vcnt",   32'(vcnt_b), 32'h0);
    check("async_busy",   32'(busy_b), 32'h0);
    check("async_done",   32'(done_b), 32'h0);
    check("async_pass",   32'(pass_b), 32'h0);
    check("async_s_done", 32'(done_s), 32'h0);
    @(negedge CK);
    RST = 1'b0;
    tick();

    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 23'h000003);
    check("v1_sig",  32'(sig_s),  32'h3);
    check("v1_vcnt", 32'(vcnt_s), 32'h1);
    drive(1'b0, 1'b0, 23'h7FFFFF);
    check("gap1_sig",  32'(sig_s),  32'h3);
    check("gap1_vcnt", 32'(vcnt_s), 32'h1);
    drive(1'b1, 1'b1, 23'h000010);
    check("runstart_sig",  32'(sig_s),  32'h16);
    check("runstart_vcnt", 32'(vcnt_s), 32'h2);
    check("runstart_busy", 32'(busy_s), 32'h1);
    drive(1'b0, 1'b0, 23'h0000FF);
    check("gap2_sig", 32'(sig_s), 32'h16);
    drive(1'b0, 1'b1, 23'h000100);
    check("v3_sig",  32'(sig_s),  32'h12C);
    check("v3_vcnt", 32'(vcnt_s), 32'h3);
    check("v3_done", 32'(done_s), 32'h0);
    drive(1'b0, 1'b1, 23'h400000);
    check("fin_sig",  32'(sig_s),  32'(GOLD4));
    check("fin_vcnt", 32'(vcnt_s), 32'h4);
    check("fin_done", 32'(done_s), 32'h1);
    check("fin_busy", 32'(busy_s), 32'h0);
    check("fin_pass", 32'(pass_s), 32'h1);
    drive(1'b0, 1'b1, 23'h001234);
    check("post_sig",  32'(sig_s),  32'(GOLD4));
    check("post_vcnt", 32'(vcnt_s), 32'h4);
    check("post_done", 32'(done_s), 32'h1);
    check("post_pass", 32'(pass_s), 32'h1);

    drive(1'b1, 1'b1, 23'h000007);
    check("re_sig",  32'(sig_s),  32'h0);
    check("re_vcnt", 32'(vcnt_s), 32'h0);
    check("re_done", 32'(done_s), 32'h0);
    check("re_busy", 32'(busy_s), 32'h1);
    check("re_pass", 32'(pass_s), 32'h0);
    drive(1'b0, 1'b1, 23'h000003);
    drive(1'b0, 1'b1, 23'h000010);
    drive(1'b0, 1'b1, 23'h000101);
    drive(1'b0, 1'b1, 23'h400000);
    check("bad_sig",  32'(sig_s),  32'h40025A);
    check("bad_done", 32'(done_s), 32'h1);
    check("bad_pass", 32'(pass_s), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/s713_resp_compactor.md
Name: s713_resp_compactor

Overview:
- Downstream response-compaction stage for the s713 benchmark core.
- Consumes the core's 23 primary outputs each test cycle and folds them into a 23-bit MISR signature over a fixed-length vector run.
- Reports the signature and a pass/fail result against a golden value.
- Used by the benchmark BIST harness so the core's sequential behaviour can be checked with one compare instead of per-vector checks.

Parameters:
- W, 23, response/signature width; equals the s713 output count.
- POLY, 23'h000021, MISR feedback taps (x^23+x^5+1).
- SEED, 23'h000000, signature value loaded on reset and on START.
- NVEC, 256, number of valid response vectors per run (NVEC >= 1).
- GOLDEN, 23'h000000, expected final signature.

Ports:
- CK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- START  in  1  one-cycle pulse that begins a run.
- VALID  in  1  RESP is a vector to compact this cycle.
- RESP  in  W  s713 outputs, packed {G107,G83,...,G101BF} in fixed harness order.
- BUSY  out  1  run in progress.
- DONE  out  1  run complete; held until the next START or RST.
- PASS  out  1  SIG==GOLDEN; meaningful only while DONE=1, 0 otherwise.
- SIG  out  W  current signature.
- VCNT  out  $clog2(NVEC+1)  vectors compacted in the current run.

Behaviour:
- All outputs are registered. No combinational path from inputs to outputs.
- Reset (async, any state, including mid-run): state=IDLE, SIG=SEED, VCNT=0, BUSY=0, DONE=0, PASS=0.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: START -> RUN. On the same edge: SIG<=SEED, VCNT<=0, BUSY<=1. VALID is ignored.
  - RUN: each edge with VALID=1, SIG <= ({SIG[W-2:0],1'b0} ^ (SIG[W-1] ? POLY : 0)) ^ RESP, and VCNT<=VCNT+1. VALID=0 holds SIG and VCNT.
  - RUN exit: on the edge that takes VCNT to NVEC -> DONE, BUSY<=0, DONE<=1. PASS<=(next SIG==GOLDEN) on the same edge, so DONE and PASS rise together, one cycle after the last VALID.
  - DONE: SIG, VCNT and PASS hold. VALID is ignored. START -> RUN with the same reload as from IDLE; DONE<=0, PASS<=0 on that edge.
- START while in RUN is ignored (no restart, no count change).
- START and VALID in the same cycle from IDLE/DONE: START wins and that VALID is not compacted.
- VCNT never exceeds NVEC and never wraps.
- Latency: SIG reflects a VALID vector on the edge after it is presented.

Decomposition:
- Shared package s713_bist_pkg holds:
  - W, POLY, SEED localparams;
  - the state enum {IDLE, RUN, DONE};
  - the output-packing order constant shared with the upstream stimulus sequencer.
- One sub-module, s713_misr_reg: a W-bit MISR register with load (seed), enable (VALID&&RUN) and async RST.
- The FSM, counter and compare stay in the top.

Test Plan:
- Reset/idle: assert RST mid-run with SIG=23'h1234AB, VCNT=5 -> immediately SIG=0, VCNT=0, BUSY=0, DONE=0, PASS=0. VALID in IDLE leaves SIG=0.
- Basic shift: NVEC=256, START, then RESP=23'h000001 with VALID, then RESP=0 with VALID -> SIG=23'h000001, then 23'h000002. VCNT=1, then 2.
- Feedback tap: force SIG=23'h400000 via a single RESP=23'h400000 from seed 0, then RESP=0 VALID -> SIG=23'h000021.
- Gaps and completion: NVEC=4, four VALID=1 vectors with VALID=0 gaps -> SIG/VCNT hold across gaps. DONE=1 and BUSY=0 the cycle after the 4th vector; VCNT=4. Extra VALID leaves SIG unchanged.
- Pass/fail: GOLDEN set to the model's signature for a 4-vector stream -> PASS=1. Flip one bit in vector 3 -> PASS=0 with DONE=1.
- Restart races: START during RUN -> VCNT continues uninterrupted. START+VALID in DONE -> SIG=SEED, VCNT=0, DONE=0, BUSY=1, and that vector is not compacted.
